odometer_seq_ctrl_stacked: RTL and testbench

- Sequencer for one stacked odometer measurement.
- Receives a serial scan word holding the 5-bit control field and a 16-bit measurement window.
- On START it stages the control field onto CTRL_IN and pulses LOAD to the control latch, then waits a settle period.
- It then opens the measurement window (MEAS_EN) for the programmed number of cycles and flags DONE.

---
 rtl/odometer_seq_ctrl_stacked.sv | 136 +++++++++++++
 tb/tb_odometer_seq_ctrl_stacked.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/odometer_seq_ctrl_stacked.sv
// Stacked odometer measurement sequencer: scan in control + window, strobe the
// control latch, settle, then open the measurement window and flag completion.
module odometer_seq_ctrl_stacked #(
  parameter int CTRL_W     = 5,
  parameter int WIN_W      = 16,
  parameter int LOAD_HIGH  = 2,
  parameter int SETTLE_CYC = 4
) (
  input  logic              SCAN_CLK,
  input  logic              RESET,
  input  logic              SCAN_IN,
  input  logic              SCAN_EN,
  input  logic              START,
  input  logic              ABORT,
  output logic [0:CTRL_W-1] CTRL_IN,
  output logic              LOAD,
  output logic              MEAS_EN,
  output logic              BUSY,
  output logic              DONE
);
  localparam int SR_W    = CTRL_W + WIN_W;
  localparam int CNT_MAX = (LOAD_HIGH > SETTLE_CYC) ? LOAD_HIGH : SETTLE_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, LOADH, SETTLE, MEAS} state_t;

  state_t            state_q, state_d;
  // MSB of sr_q is the first-shifted bit, so CTRL sits in the top CTRL_W bits
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load_q, load_d;
  logic              meas_q, meas_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_ff @(posedge SCAN_CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      sr_q    <= '0;
      ctrl_q  <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      meas_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      ctrl_q  <= ctrl_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      meas_q  <= meas_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    ctrl_d  = ctrl_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    load_d  = load_q;
    meas_d  = meas_q;
    busy_d  = busy_q;
    done_d  = done_q;
    if (state_q != IDLE && ABORT) begin
      // staged control word is deliberately left on CTRL_IN
      state_d = IDLE;
      load_d  = 1'b0;
      meas_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            ctrl_d  = sr_q[SR_W-1 -: CTRL_W];
            win_d   = sr_q[WIN_W-1:0];
            done_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = SETUP;
          end else if (SCAN_EN) begin
            sr_d = {sr_q[SR_W-2:0], SCAN_IN};
          end
        end
        SETUP: begin
          load_d  = 1'b1;
          cnt_d   = CNT_W'(LOAD_HIGH - 1);
          state_d = LOADH;
        end
        LOADH: begin
          if (cnt_q == '0) begin
            load_d  = 1'b0;
            cnt_d   = CNT_W'(SETTLE_CYC - 1);
            state_d = SETTLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        SETTLE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (win_q != '0) begin
            meas_d  = 1'b1;
            state_d = MEAS;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
        MEAS: begin
          win_d = win_q - 1'b1;
          if (win_q == WIN_W'(1)) begin
            meas_d  = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign CTRL_IN = ctrl_q;
  assign LOAD    = load_q;
  assign MEAS_EN = meas_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
endmodule

// File: tb/tb_odometer_seq_ctrl_stacked.sv
// Scoreboard bench: stimulus queues the expected shape of each sequence, a
// negedge monitor measures each BUSY episode and compares against the queue.
module tb_odometer_seq_ctrl_stacked;
  logic       clk = 1'b0;
  logic       RESET, SCAN_IN, SCAN_EN, START, ABORT;
  logic [0:4] CTRL_IN;
  logic       LOAD, MEAS_EN, BUSY, DONE;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0] ctrl;
    int ld_start, ld_len, ms_start, ms_len, end_t;
    int done;
  } exp_t;
  exp_t sb[$];

  odometer_seq_ctrl_stacked dut (
    .SCAN_CLK(clk), .RESET(RESET), .SCAN_IN(SCAN_IN), .SCAN_EN(SCAN_EN),
    .START(START), .ABORT(ABORT), .CTRL_IN(CTRL_IN), .LOAD(LOAD),
    .MEAS_EN(MEAS_EN), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: one record per BUSY episode, t counts samples since BUSY rose
  bit         in_seq = 0;
  int         t, ld_start, ld_len, ms_start, ms_len, ovl;
  logic [4:0] ctrl_obs;
  always @(negedge clk) begin
    if (BUSY) begin
      if (!in_seq) begin
        in_seq = 1; t = 0; ld_start = -1; ld_len = 0;
        ms_start = -1; ms_len = 0; ovl = 0; ctrl_obs = CTRL_IN;
      end
      if (LOAD) begin
        if (ld_start < 0) ld_start = t;
        ld_len++;
        if (CTRL_IN != ctrl_obs) ovl = 1;
      end
      if (MEAS_EN) begin
        if (ms_start < 0) ms_start = t;
        ms_len++;
      end
      if (LOAD && MEAS_EN) ovl = 1;
      t++;
    end else if (in_seq) begin
      in_seq = 0;
      if (sb.size() == 0) begin
        chk("unexpected_seq", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ctrl_in",   int'(ctrl_obs), int'(e.ctrl));
        chk("ld_start",  ld_start, e.ld_start);
        chk("ld_len",    ld_len,   e.ld_len);
        chk("ms_start",  ms_start, e.ms_start);
        chk("ms_len",    ms_len,   e.ms_len);
        chk("end_t",     t,        e.end_t);
        chk("done_end",  int'(DONE), e.done);
        chk("overlap_or_ctrl_change", ovl, 0);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [4:0] c, input logic [15:0] w);
    logic [20:0] word;
    word = {c, w};
    for (int i = 20; i >= 0; i--) begin
      SCAN_IN = word[i];
      SCAN_EN = 1'b1;
      tick();
    end
    SCAN_EN = 1'b0;
  endtask

  task automatic start_pulse();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic push(input logic [4:0] c, input int lds, input int ldl,
                      input int mss, input int msl, input int et, input int d);
    exp_t e;
    e.ctrl = c; e.ld_start = lds; e.ld_len = ldl; e.ms_start = mss;
    e.ms_len = msl; e.end_t = et; e.done = d;
    sb.push_back(e);
  endtask

  initial begin
    RESET = 1'b1; SCAN_IN = 1'b0; SCAN_EN = 1'b0; START = 1'b0; ABORT = 1'b0;
    tick(2);
    chk("rst_ctrl_in", int'(CTRL_IN), 0);
    chk("rst_load", int'(LOAD), 0);
    chk("rst_meas", int'(MEAS_EN), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    RESET = 1'b0;
    tick();

    // nominal: CTRL=10110, WIN=10 -> DONE 17 edges after START sample
    scan(5'b10110, 16'd10);
    push(5'b10110, 1, 2, 7, 10, 17, 1);
    start_pulse();
    chk("ctrl_staged", int'(CTRL_IN), int'(5'b10110));
    tick(20);

    // empty window: no MEAS_EN, DONE after 7
    scan(5'b00001, 16'd0);
    push(5'b00001, 1, 2, -1, 0, 7, 1);
    start_pulse();
    tick(10);

    // abort sampled on edge 20 of a WIN=100 run
    scan(5'b01010, 16'd100);
    push(5'b01010, 1, 2, 7, 13, 20, 0);
    start_pulse();
    tick(19);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("abort_meas", int'(MEAS_EN), 0);
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_done", int'(DONE), 0);
    chk("abort_ctrl_kept", int'(CTRL_IN), int'(5'b01010));
    tick(2);

    // fresh run with scan noise while busy; SR must be untouched
    push(5'b01010, 1, 2, 7, 100, 107, 1);
    start_pulse();
    for (int i = 0; i < 20; i++) begin
      SCAN_EN = 1'($urandom_range(0, 1));
      SCAN_IN = 1'($urandom_range(0, 1));
      tick();
    end
    SCAN_EN = 1'b0;
    tick(95);
    // START wins over SCAN_EN in the same cycle
    push(5'b01010, 1, 2, 7, 100, 107, 1);
    START = 1'b1; SCAN_EN = 1'b1; SCAN_IN = 1'b1;
    tick();
    START = 1'b0; SCAN_EN = 1'b0;
    tick(112);

    // reset while LOAD is high
    scan(5'b11111, 16'd5);
    push(5'b11111, 1, 1, -1, 0, 2, 0);
    start_pulse();
    tick();
    RESET = 1'b1;
    tick();
    chk("mrst_load", int'(LOAD), 0);
    chk("mrst_ctrl_in", int'(CTRL_IN), 0);
    chk("mrst_busy", int'(BUSY), 0);
    chk("mrst_done", int'(DONE), 0);
    RESET = 1'b0;
    tick(2);
    // SR cleared by reset: start without scanning gives CTRL=0, WIN=0
    push(5'b00000, 1, 2, -1, 0, 7, 1);
    start_pulse();
    tick(10);

    // START held across two WIN=3 sequences
    scan(5'b10011, 16'd3);
    push(5'b10011, 1, 2, 7, 3, 10, 1);
    push(5'b10011, 1, 2, 7, 3, 10, 1);
    START = 1'b1;
    tick(12);
    START = 1'b0;
    tick(15);
    chk("final_done", int'(DONE), 1);

    tick(2);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
